// File: rtl/config_pkg.sv
// Shared types for the configuration message bus: default field widths,
// the {addr, flag, payload} message layout and the initiator state encoding.
package config_pkg;

  localparam int CFG_ADDR_SIZE    = 4;
  localparam int CFG_PAYLOAD_SIZE = 8;

  // flag is the write bit on requests and the success bit on echoes
  typedef struct packed {
    logic [CFG_ADDR_SIZE-1:0]    addr;
    logic                        flag;
    logic [CFG_PAYLOAD_SIZE-1:0] payload;
  } cfg_msg_t;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ISSUE  = 2'd1,
    WAIT   = 2'd2,
    REPORT = 2'd3
  } cfg_init_state_e;

endpackage

// File: rtl/config_initiator_if.sv
// Command, bus message and status signals of the configuration initiator.
// The master modport is the initiator's view; slave is the driver/responder side.
interface config_initiator_if
  import config_pkg::*;
#(
  parameter int ADDR_SIZE    = CFG_ADDR_SIZE,
  parameter int PAYLOAD_SIZE = CFG_PAYLOAD_SIZE,
  parameter int MAX_RETRY    = 3
);

  localparam int MSG_W = ADDR_SIZE + PAYLOAD_SIZE + 1;
  localparam int TRY_W = $clog2(MAX_RETRY + 2);

  logic                    cmd_val;
  logic                    cmd_rdy;
  logic [ADDR_SIZE-1:0]    cmd_addr;
  logic [PAYLOAD_SIZE-1:0] cmd_payload;
  logic [MSG_W-1:0]        req_msg;
  logic [MSG_W-1:0]        resp_msg;
  logic                    status_val;
  logic                    status_rdy;
  logic                    status_ok;
  logic [ADDR_SIZE-1:0]    status_addr;
  logic [TRY_W-1:0]        status_tries;
  logic                    busy;

  modport master (
    input  cmd_val, cmd_addr, cmd_payload, resp_msg, status_rdy,
    output cmd_rdy, req_msg, status_val, status_ok, status_addr, status_tries, busy
  );

  modport slave (
    output cmd_val, cmd_addr, cmd_payload, resp_msg, status_rdy,
    input  cmd_rdy, req_msg, status_val, status_ok, status_addr, status_tries, busy
  );

endinterface

// File: rtl/config_timeout_ctr.sv
// WAIT-phase timer: clr reloads, en counts down; done flags the enabled cycle
// in which the TIMEOUT-th WAIT cycle completes.
module config_timeout_ctr #(
  parameter int TIMEOUT = 8
) (
  input  logic clk,
  input  logic reset,
  input  logic clr,
  input  logic en,
  output logic done
);

  localparam int            CW   = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;
  localparam logic [CW-1:0] LOAD = CW'(TIMEOUT - 1);

  logic [CW-1:0] cnt;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cnt <= LOAD;
    end else if (clr) begin
      cnt <= LOAD;
    end else if (en && (cnt != '0)) begin
      cnt <= cnt - CW'(1);
    end
  end

  assign done = en && (cnt == '0);

endmodule

// File: rtl/config_initiator.sv
// Master-side driver for the configuration register message bus.
// Optional CONFIG_INIT_PAYLOAD_CHECK_EN: an echo must also return the written payload.
//
// state  | meaning
// IDLE   | ready for a command (cmd_rdy=1)
// ISSUE  | write message on req_msg for exactly one cycle
// WAIT   | watching resp_msg for a matching echo, timing out after TIMEOUT cycles
// REPORT | status_val held with stable fields until status_rdy
module config_initiator
  import config_pkg::*;
#(
  parameter int ADDR_SIZE    = CFG_ADDR_SIZE,
  parameter int PAYLOAD_SIZE = CFG_PAYLOAD_SIZE,
  parameter int TIMEOUT      = 8,
  parameter int MAX_RETRY    = 3
) (
  input logic                clk,
  input logic                reset,
  config_initiator_if.master bus
);

  localparam int MSG_W = ADDR_SIZE + PAYLOAD_SIZE + 1;
  localparam int TRY_W = $clog2(MAX_RETRY + 2);

`ifdef CONFIG_INIT_PAYLOAD_CHECK_EN
  localparam bit PAYLOAD_CHECK = 1'b1;
`else
  localparam bit PAYLOAD_CHECK = 1'b0;
`endif

  typedef struct packed {
    logic [ADDR_SIZE-1:0]    addr;
    logic                    flag;
    logic [PAYLOAD_SIZE-1:0] payload;
  } msg_t;

  cfg_init_state_e         state;
  logic [ADDR_SIZE-1:0]    lat_addr;
  logic [PAYLOAD_SIZE-1:0] lat_payload;
  logic [TRY_W-1:0]        tries;
  msg_t                    resp;
  logic                    match;
  logic                    tmr_clr;
  logic                    tmr_en;
  logic                    tmr_done;

  assign resp = msg_t'(bus.resp_msg);

  // an all-zero echo can never match because its success bit is clear
  assign match = resp.flag && (resp.addr == lat_addr) &&
                 (!PAYLOAD_CHECK || (resp.payload == lat_payload));

  assign tmr_clr = (state == ISSUE);
  assign tmr_en  = (state == WAIT);

  config_timeout_ctr #(
    .TIMEOUT (TIMEOUT)
  ) u_timeout (
    .clk   (clk),
    .reset (reset),
    .clr   (tmr_clr),
    .en    (tmr_en),
    .done  (tmr_done)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state            <= IDLE;
      lat_addr         <= '0;
      lat_payload      <= '0;
      tries            <= '0;
      bus.cmd_rdy      <= 1'b1;
      bus.req_msg      <= '0;
      bus.status_val   <= 1'b0;
      bus.status_ok    <= 1'b0;
      bus.status_addr  <= '0;
      bus.status_tries <= '0;
      bus.busy         <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (bus.cmd_val) begin
            lat_addr    <= bus.cmd_addr;
            lat_payload <= bus.cmd_payload;
            tries       <= '0;
            bus.req_msg <= MSG_W'({bus.cmd_addr, 1'b1, bus.cmd_payload});
            bus.cmd_rdy <= 1'b0;
            bus.busy    <= 1'b1;
            state       <= ISSUE;
          end
        end

        ISSUE: begin
          bus.req_msg <= '0;
          tries       <= tries + TRY_W'(1);
          state       <= WAIT;
        end

        WAIT: begin
          // a match on the timeout cycle still wins over the retry
          if (match) begin
            bus.status_val   <= 1'b1;
            bus.status_ok    <= 1'b1;
            bus.status_addr  <= lat_addr;
            bus.status_tries <= tries;
            state            <= REPORT;
          end else if (tmr_done) begin
            if (tries <= TRY_W'(MAX_RETRY)) begin
              bus.req_msg <= MSG_W'({lat_addr, 1'b1, lat_payload});
              state       <= ISSUE;
            end else begin
              bus.status_val   <= 1'b1;
              bus.status_ok    <= 1'b0;
              bus.status_addr  <= lat_addr;
              bus.status_tries <= tries;
              state            <= REPORT;
            end
          end
        end

        REPORT: begin
          if (bus.status_rdy) begin
            bus.status_val <= 1'b0;
            bus.cmd_rdy    <= 1'b1;
            bus.busy       <= 1'b0;
            state          <= IDLE;
          end
        end

        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule
